// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and default width.
package serial_add_ctrl_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } sa_state_t;

endpackage

// File: rtl/serial_add_ctrl_add1bit.sv
// Single-bit half adder; two of these plus a carry flop form the serial full-adder slice.
module add1bit (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: shares one half-adder pair and a carry flop across all bits, LSB first.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   sa_state_t        state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;

   logic s0, c0, bit_s, c1;
   logic [WIDTH-1:0] sum_sr_next;

   add1bit ha0 (.a_i(a_sr_q[0]), .b_i(b_sr_q[0]), .s_o(s0),    .c_o(c0));
   add1bit ha1 (.a_i(s0),        .b_i(carry_q),   .s_o(bit_s), .c_o(c1));

   // New bit enters at the MSB so after WIDTH shifts bit 0 has reached position 0.
   assign sum_sr_next = (sum_sr_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_SHIFT;
               a_sr_d   = a;
               b_sr_d   = b;
               sum_sr_d = '0;
               cnt_d    = '0;
               carry_d  = 1'b0;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            carry_d  = c0 | c1;
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = sum_sr_next;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
               sum_d   = sum_sr_next;
               cout_d  = c0 | c1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
      end
   end

   // Status flags decode straight from the state register, so no input reaches an output combinationally.
   assign busy = (state_q == ST_SHIFT);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=4 and WIDTH=1.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start4 = 1'b0, start1 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       busy4, done4, cout4, busy1, done1, cout1;
   logic [3:0] sum4;
   logic [0:0] sum1;

   int total = 0;
   int bad = 0;

   serial_add_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one WIDTH=4 add from IDLE, checking busy over the whole window and the result.
   task automatic run4(input logic [3:0] av, input logic [3:0] bv,
                       input logic [3:0] es, input logic ec);
      a4 = av; b4 = bv; start4 = 1'b1;
      step();
      start4 = 1'b0;
      chk("busy_t0", busy4, 1);
      for (int i = 1; i < 4; i++) begin
         step();
         chk("busy_mid", busy4, 1);
         chk("done_mid", done4, 0);
      end
      step();
      chk("done_t4", done4, 1);
      chk("busy_t4", busy4, 0);
      chk("sum_t4", sum4, es);
      chk("cout_t4", cout4, ec);
   endtask

   initial begin
      logic [4:0] ref5;
      logic [1:0] ref2;
      int seen;

      #2;
      chk("rst_busy", busy4, 0);
      chk("rst_done", done4, 0);
      chk("rst_sum", sum4, 0);
      chk("rst_cout", cout4, 0);
      step();
      reset = 1'b1;
      step();

      run4(4'd5, 4'd3, 4'd8, 1'b0);
      step();
      chk("idle_done", done4, 0);
      chk("idle_busy", busy4, 0);
      chk("hold_sum", sum4, 8);

      run4(4'd15, 4'd1, 4'd0, 1'b1);
      step();
      run4(4'd15, 4'd15, 4'd14, 1'b1);

      // Back-to-back accept from DONE; old result must stay visible while the new one computes.
      a4 = 4'd7; b4 = 4'd9; start4 = 1'b1;
      step();
      start4 = 1'b0;
      chk("b2b_busy", busy4, 1);
      chk("b2b_hold_sum", sum4, 14);
      for (int i = 1; i < 4; i++) begin
         step();
         chk("b2b_hold_sum_mid", sum4, 14);
         chk("b2b_hold_cout_mid", cout4, 1);
      end
      step();
      chk("b2b_done", done4, 1);
      chk("b2b_sum", sum4, 0);
      chk("b2b_cout", cout4, 1);
      step();

      // A start during SHIFT is ignored.
      a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
      step();
      start4 = 1'b0;
      step();
      a4 = 4'd2; b4 = 4'd2; start4 = 1'b1;
      step();
      start4 = 1'b0;
      a4 = 4'd0; b4 = 4'd0;
      step();
      step();
      chk("ign_done", done4, 1);
      chk("ign_sum", sum4, 2);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done4 || busy4) seen++;
      end
      chk("ign_no_second", seen, 0);

      // Asynchronous reset during the second SHIFT cycle of 6+6.
      a4 = 4'd6; b4 = 4'd6; start4 = 1'b1;
      step();
      start4 = 1'b0;
      step();
      chk("pre_rst_busy", busy4, 1);
      chk("pre_rst_sum", sum4, 2);
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", busy4, 0);
      chk("arst_done", done4, 0);
      chk("arst_sum", sum4, 0);
      chk("arst_cout", cout4, 0);
      step();
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done4 || busy4) seen++;
      end
      chk("arst_no_done", seen, 0);

      // Exhaustive WIDTH=4, back-to-back.
      for (int k = 0; k < 256; k++) begin
         a4 = 4'(k >> 4); b4 = 4'(k);
         ref5 = {1'b0, a4} + {1'b0, b4};
         start4 = 1'b1;
         step();
         start4 = 1'b0;
         for (int i = 0; i < 3; i++) step();
         step();
         if (!done4) chk("ex4_done", done4, 1);
         chk("ex4_sum", {cout4, sum4}, ref5);
      end
      step();
      chk("ex4_idle", busy4 | done4, 0);

      // Exhaustive WIDTH=1: one cycle in SHIFT.
      for (int k = 0; k < 4; k++) begin
         a1 = 1'(k >> 1); b1 = 1'(k);
         ref2 = {1'b0, a1} + {1'b0, b1};
         start1 = 1'b1;
         step();
         start1 = 1'b0;
         chk("ex1_busy", busy1, 1);
         step();
         chk("ex1_done", done1, 1);
         chk("ex1_sum", {cout1, sum1}, ref2);
      end
      step();
      chk("ex1_idle", busy1 | done1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
